xcorr_peak_find: RTL and testbench
==================================

# xcorr_peak_find

Peak detector for the cross-correlation receive path. It consumes the block-floating-point frame stream produced by the correlation IFFT stage: 12-bit I/Q samples, a per-frame exponent, a valid strobe and an end-of-frame strobe. For each frame it computes |I|²+|Q|² per sample, tracks the largest value and its bin index, and at end of frame emits a one-cycle result: peak index, peak magnitude, frame exponent, threshold detect and a frame-length error flag.

## Interface

Parameters:
- N_LOG2, 10, log2 of nominal frame length (1024 bins)
- DW, 12, I/Q sample width (signed)
- MAG_W, 2*DW, magnitude width (unsigned); do not override

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- ival  in  1  input sample valid
- idata_i  in  DW  signed I sample
- idata_q  in  DW  signed Q sample
- iexp  in  8  frame block exponent, passed through unchanged
- ieop  in  1  last sample of frame; qualified by ival
- thr  in  MAG_W  detect threshold, sampled with the eop sample
- oval  out  1  result valid, one-cycle pulse per frame
- opeak_idx  out  N_LOG2  bin index of the peak
- opeak_mag  out  MAG_W  peak magnitude I²+Q²
- oexp  out  8  iexp captured with the eop sample
- odet  out  1  opeak_mag > thr
- oerr  out  1  frame length was not 2^N_LOG2
- ofrm_cnt  out  16  count of completed frames, wraps at 65535→0

## Operation

- Sample counter idx (N_LOG2 bits):
  - Increments on every ival.
  - Clears to 0 on the cycle after an accepted ival&ieop.
  - Wraps modulo 2^N_LOG2.
- Overrun flag:
  - Sets when idx wraps from 2^N_LOG2−1 to 0 without ieop.
  - Sticky until the end of that frame.
- Pipeline, 4 stages. Each stage carries valid, sof (idx==0), eop, idx, exp and thr tags.
  - S1: register the I/Q sample and the tags.
  - S2: I² and Q², signed DW×DW products, each 2·DW−1 bits.
  - S3: mag = I²+Q² in MAG_W bits. The maximum is 2^23 at I=Q=−2048, so there is no overflow.
  - S4: running max update.
    - If sof, max←mag and max_idx←idx unconditionally.
    - Otherwise, only if mag > max (strictly greater). Ties keep the earliest index.
- Gaps: ival may drop at any cycle, including mid-frame. Bubbles flow through the pipeline without changing state.
- End of frame: when the eop-tagged sample leaves S4, the following are registered and oval is pulsed:
  - opeak_idx, opeak_mag (updated max including that sample) and oexp.
  - odet = (final max > thr).
  - oerr = (eop idx ≠ 2^N_LOG2−1) OR overrun.
  - ofrm_cnt increments in the same cycle.
- Frame reset: frames may be back-to-back. The sof tag reinitialises the max, so no dead cycle is needed between frames.
- Single-sample frame (ival&ieop with idx==0): valid. Peak index is 0 and oerr=1.
- Outputs other than oval hold their values until the next result.

## Timing

- An eop sample accepted at rising edge t gives oval=1 during the cycle after edge t+4.
- Latency is fixed at 4 cycles, independent of gaps.
- Throughput is one sample per clock, sustained.
- No backpressure: the block is always ready. ival without ieop never produces oval.
- Reset values are 0 for all of: oval, opeak_idx, opeak_mag, oexp, odet, oerr, ofrm_cnt, idx, overrun, max, and all pipeline valid tags.
- Reset mid-frame:
  - The partial frame is discarded and no oval is produced for it.
  - The first sample after rst deasserts is bin 0.
- Reset during the 4-cycle drain after an eop: that oval is suppressed.

## Test plan

- Impulse frame:
  - Stimulus: 1024 samples, all zero except bin 37 = (1000, 0); thr=500000.
  - Response: oval 4 cycles after eop; opeak_idx=37, opeak_mag=1000000, odet=1, oerr=0, ofrm_cnt=1.
- Tie and negative extremes:
  - Stimulus: bins 5 and 900 = (−2048, −2048); others (3, 4); thr=2^23.
  - Response: opeak_idx=5, opeak_mag=8388608, odet=0 (strict compare).
- Short and long frames:
  - Stimulus: eop at idx 99.
  - Response: oerr=1, peak taken from bins 0..99.
  - Stimulus: next frame of 1030 samples with eop on the last.
  - Response: oerr=1 (overrun).
  - Stimulus: next 1024-sample frame.
  - Response: oerr=0.
- Back-to-back with gaps:
  - Stimulus: two frames with no gap between eop and next sof, random ival gaps inside frames; peaks at 10 (mag 400) and 1000 (mag 900); iexp=3 then 7.
  - Response: two oval pulses, with (10, 400, oexp=3) then (1000, 900, oexp=7); ofrm_cnt=1 then 2.
- Reset mid-frame:
  - Stimulus: assert rst at sample 500, release, then send a full impulse frame at bin 2.
  - Response: no oval for the aborted frame; a single oval with opeak_idx=2 and ofrm_cnt=1.
- Counter wrap:
  - Stimulus: 65536 single-sample frames (ival&ieop each cycle).
  - Response: an oval every cycle after the first 4, oerr=1 on each, and ofrm_cnt wraps to 0 on the last frame.

Source files
------------

// File: rtl/xcorr_peak_find_if.sv
// rtl/xcorr_peak_find_if.sv - sample stream in / per-frame peak result out for xcorr_peak_find
interface xcorr_peak_find_if #(
    parameter int N_LOG2 = 10,
    parameter int DW     = 12,
    parameter int MAG_W  = 2 * DW
);
    logic                     ival;
    logic signed [DW-1:0]     idata_i;
    logic signed [DW-1:0]     idata_q;
    logic [7:0]               iexp;
    logic                     ieop;
    logic [MAG_W-1:0]         thr;

    logic                     oval;
    logic [N_LOG2-1:0]        opeak_idx;
    logic [MAG_W-1:0]         opeak_mag;
    logic [7:0]               oexp;
    logic                     odet;
    logic                     oerr;
    logic [15:0]              ofrm_cnt;

    modport master (
        output ival, idata_i, idata_q, iexp, ieop, thr,
        input  oval, opeak_idx, opeak_mag, oexp, odet, oerr, ofrm_cnt
    );

    modport slave (
        input  ival, idata_i, idata_q, iexp, ieop, thr,
        output oval, opeak_idx, opeak_mag, oexp, odet, oerr, ofrm_cnt
    );
endinterface

// File: rtl/xcorr_peak_find.sv
// rtl/xcorr_peak_find.sv - per-frame |I|^2+|Q|^2 peak search with index, threshold detect and length check
module xcorr_peak_find #(
    parameter int N_LOG2 = 10,
    parameter int DW     = 12,
    parameter int MAG_W  = 2 * DW
) (
    input  logic             clk,
    input  logic             rst,
    xcorr_peak_find_if.slave bus
);
    localparam int PW = 2 * DW - 1;
    localparam logic [N_LOG2-1:0] IDX_LAST = '1;

    typedef struct packed {
        logic              sof;
        logic              eop;
        logic              err;
        logic [N_LOG2-1:0] idx;
        logic [7:0]        exp;
        logic [MAG_W-1:0]  thr;
    } tag_t;

    logic [N_LOG2-1:0] idx;
    logic              overrun;

    logic                 v1, v2, v3, v4;
    tag_t                 t1, t2, t3, t4;
    logic signed [DW-1:0] i1, q1;
    logic signed [2*DW-1:0] prod_i, prod_q;
    logic [PW-1:0]        ii2, qq2;
    logic [MAG_W-1:0]     mag3;
    logic [MAG_W-1:0]     max_mag;
    logic [N_LOG2-1:0]    max_idx;

    // Overrun latches when the counter wraps without an eop, so an over-long frame is still flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            overrun <= 1'b0;
        end else if (bus.ival) begin
            if (bus.ieop) begin
                idx     <= '0;
                overrun <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
                if (idx == IDX_LAST) overrun <= 1'b1;
            end
        end
    end

    assign prod_i = i1 * i1;
    assign prod_q = q1 * q1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
            t1 <= '0;   t2 <= '0;   t3 <= '0;   t4 <= '0;
            i1 <= '0;   q1 <= '0;
            ii2 <= '0;  qq2 <= '0;  mag3 <= '0;
            max_mag <= '0;
            max_idx <= '0;
        end else begin
            v1      <= bus.ival;
            i1      <= bus.idata_i;
            q1      <= bus.idata_q;
            t1.sof  <= (idx == '0);
            t1.eop  <= bus.ieop;
            t1.err  <= (idx != IDX_LAST) || overrun;
            t1.idx  <= idx;
            t1.exp  <= bus.iexp;
            t1.thr  <= bus.thr;

            v2  <= v1;
            t2  <= t1;
            ii2 <= prod_i[PW-1:0];
            qq2 <= prod_q[PW-1:0];

            v3   <= v2;
            t3   <= t2;
            mag3 <= MAG_W'(ii2) + MAG_W'(qq2);

            v4 <= v3;
            t4 <= t3;
            // Strict compare keeps the earliest bin on ties; sof restarts the search
            if (v3 && (t3.sof || (mag3 > max_mag))) begin
                max_mag <= mag3;
                max_idx <= t3.idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.oval      <= 1'b0;
            bus.opeak_idx <= '0;
            bus.opeak_mag <= '0;
            bus.oexp      <= '0;
            bus.odet      <= 1'b0;
            bus.oerr      <= 1'b0;
            bus.ofrm_cnt  <= '0;
        end else begin
            bus.oval <= v4 && t4.eop;
            if (v4 && t4.eop) begin
                bus.opeak_idx <= max_idx;
                bus.opeak_mag <= max_mag;
                bus.oexp      <= t4.exp;
                bus.odet      <= (max_mag > t4.thr);
                bus.oerr      <= t4.err;
                bus.ofrm_cnt  <= bus.ofrm_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_xcorr_peak_find.sv
// tb/tb_xcorr_peak_find.sv - scoreboard bench for xcorr_peak_find
module tb_xcorr_peak_find;
    localparam int N_LOG2 = 10;
    localparam int DW     = 12;
    localparam int MAG_W  = 2 * DW;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    xcorr_peak_find_if #(.N_LOG2(N_LOG2), .DW(DW), .MAG_W(MAG_W)) bus ();

    xcorr_peak_find #(.N_LOG2(N_LOG2), .DW(DW), .MAG_W(MAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int     cyc;
        int     idx;
        longint mag;
        int     exp;
        int     det;
        int     err;
        int     cnt;
    } exp_t;

    exp_t sbq[$];

    int     m_idx;
    int     m_ovr;
    longint m_max;
    int     m_midx;
    int     m_frm;

    int fi[0:1039];
    int fq[0:1039];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.oval === 1'b1) begin
            if (sbq.size() == 0) begin
                check_val("spurious_oval", 1, 0);
            end else begin
                e = sbq.pop_front();
                check_val("oval_cycle", cyc, e.cyc);
                check_val("peak_idx", bus.opeak_idx, e.idx);
                check_val("peak_mag", bus.opeak_mag, e.mag);
                check_val("oexp", bus.oexp, e.exp);
                check_val("odet", bus.odet, e.det);
                check_val("oerr", bus.oerr, e.err);
                check_val("frm_cnt", bus.ofrm_cnt, e.cnt);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int si, input int sq, input bit eop, input int ex, input longint th);
        longint mag;
        exp_t   e;
        bus.ival    = 1'b1;
        bus.idata_i = DW'(si);
        bus.idata_q = DW'(sq);
        bus.ieop    = eop;
        bus.iexp    = 8'(ex);
        bus.thr     = MAG_W'(th);
        mag = longint'(si) * si + longint'(sq) * sq;
        if (m_idx == 0 || mag > m_max) begin
            m_max  = mag;
            m_midx = m_idx;
        end
        if (eop) begin
            m_frm = (m_frm + 1) % 65536;
            e.cyc = cyc + 5;
            e.idx = m_midx;
            e.mag = m_max;
            e.exp = ex % 256;
            e.det = (m_max > th) ? 1 : 0;
            e.err = (m_idx != 1023 || m_ovr != 0) ? 1 : 0;
            e.cnt = m_frm;
            sbq.push_back(e);
            m_idx = 0;
            m_ovr = 0;
        end else begin
            if (m_idx == 1023) m_ovr = 1;
            m_idx = (m_idx + 1) % 1024;
        end
        @(posedge clk);
        #1;
        bus.ival = 1'b0;
        bus.ieop = 1'b0;
    endtask

    task automatic send_frame(input int len, input int ex, input longint th, input bit gaps);
        for (int k = 0; k < len; k++) begin
            if (gaps && k != 0 && $urandom_range(3) == 0) idle($urandom_range(3, 1));
            sample(fi[k], fq[k], k == len - 1, ex, th);
        end
    endtask

    task automatic fill(input int vi, input int vq);
        for (int k = 0; k < 1040; k++) begin
            fi[k] = vi;
            fq[k] = vq;
        end
    endtask

    task automatic do_reset();
        bus.ival = 1'b0;
        bus.ieop = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        m_idx = 0; m_ovr = 0; m_max = 0; m_midx = 0; m_frm = 0;
        sbq.delete();
        idle(1);
        check_val("rst_oval", bus.oval, 0);
        check_val("rst_peak_idx", bus.opeak_idx, 0);
        check_val("rst_peak_mag", bus.opeak_mag, 0);
        check_val("rst_oexp", bus.oexp, 0);
        check_val("rst_odet", bus.odet, 0);
        check_val("rst_oerr", bus.oerr, 0);
        check_val("rst_frm_cnt", bus.ofrm_cnt, 0);
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        rst = 1'b1;
        bus.ival = 1'b0; bus.ieop = 1'b0;
        bus.idata_i = '0; bus.idata_q = '0;
        bus.iexp = '0; bus.thr = '0;
        do_reset();

        // impulse at bin 37
        fill(0, 0);
        fi[37] = 1000;
        send_frame(1024, 8'h11, 500000, 1'b0);
        idle(3);

        // tie between two negative full-scale bins, threshold equal to peak
        fill(3, 4);
        fi[5] = -2048;   fq[5] = -2048;
        fi[900] = -2048; fq[900] = -2048;
        send_frame(1024, 2, 64'd8388608, 1'b0);
        idle(2);

        // short, long (overrun) and nominal frames
        fill(1, 1);
        fi[50] = 300; fq[50] = 400;
        send_frame(100, 4, 1000, 1'b0);
        for (int k = 0; k < 1040; k++) begin
            fi[k] = int'($urandom_range(200)) - 100;
            fq[k] = int'($urandom_range(200)) - 100;
        end
        send_frame(1030, 5, 15000, 1'b1);
        send_frame(1024, 6, 15000, 1'b1);
        idle(2);

        // back-to-back frames with internal gaps
        fill(0, 0);
        fi[10] = 20;
        send_frame(1024, 3, 100, 1'b1);
        fill(0, 0);
        fq[1000] = -30;
        send_frame(1024, 7, 100, 1'b1);
        idle(8);

        // reset mid-frame, then impulse at bin 2
        fill(5, 5);
        for (int k = 0; k < 500; k++) sample(fi[k], fq[k], 1'b0, 1, 10);
        do_reset();
        fill(0, 0);
        fi[2] = 1000;
        send_frame(1024, 9, 500000, 1'b0);
        idle(8);

        // frame counter wrap with single-sample frames
        do_reset();
        for (int n = 0; n < 65536; n++) begin
            sample(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
                   1'b1, n % 256, longint'($urandom_range(24'hFFFFFF)));
        end
        idle(10);
        check_val("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
